tlc_multi_phase: RTL and testbench

//  Parametrised multi-phase traffic-light controller for the sequential benchmark set.

---
 rtl/tlc_multi_phase.sv | 156 +++++++++++++++
 tb/tb_tlc_multi_phase.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tlc_multi_phase.sv
// Multi-phase traffic-light controller: round-robin green service with min/gap/max timing,
// yellow and all-red clearance. Optional preemption is compiled in with `define TLC_PREEMPT_EN.
module tlc_multi_phase #(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = 6,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1
) (
    input  logic                          CK,
    input  logic                          RSTN,
    input  logic                          EN,
    input  logic [NUM_PHASES-1:0]         REQ,
    output logic [NUM_PHASES-1:0]         GRN,
    output logic [NUM_PHASES-1:0]         YEL,
    output logic [NUM_PHASES-1:0]         RED,
    output logic [$clog2(NUM_PHASES)-1:0] PHASE,
    output logic [NUM_PHASES-1:0]         PEND,
`ifdef TLC_PREEMPT_EN
    input  logic                          PRE_REQ,
    input  logic [$clog2(NUM_PHASES)-1:0] PRE_PHASE,
`endif
    output logic [1:0]                    DBG_STATE
);

    localparam int PW = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [NUM_PHASES-1:0] pend_q, pend_d;
    logic [NUM_PHASES-1:0] grn_q, grn_d, yel_q, yel_d, red_q;

    logic [PW-1:0]         rr_next, cand;
    logic                  found;
    logic [NUM_PHASES-1:0] cur_oh, nxt_oh, green_mask;
    logic [CNT_W:0]        k;
    logic                  other, pre_req_w, pre_act, pre_hit;
    logic [PW-1:0]         pre_ph_w;

`ifdef TLC_PREEMPT_EN
    assign pre_req_w = PRE_REQ;
    assign pre_ph_w  = PRE_PHASE;
`else
    assign pre_req_w = 1'b0;
    assign pre_ph_w  = '0;
`endif

    // Round-robin pick: first pending phase after the current one, else plain successor.
    always_comb begin
        rr_next = '0;
        found   = 1'b0;
        cand    = phase_q;
        for (int i = 0; i < NUM_PHASES; i++) begin
            cand = (cand == PW'(NUM_PHASES - 1)) ? '0 : cand + 1'b1;
            if (i == 0) begin
                rr_next = cand;
            end
            if (!found && pend_q[cand]) begin
                found   = 1'b1;
                rr_next = cand;
            end
        end
    end

    always_comb begin
        k          = {1'b0, cnt_q} + 1'b1;
        cur_oh     = '0;
        cur_oh[phase_q] = 1'b1;
        other      = |(pend_q & ~cur_oh);
        pre_act    = pre_req_w && (int'(pre_ph_w) < NUM_PHASES);
        pre_hit    = pre_act && (pre_ph_w == phase_q);
        state_d    = state_q;
        phase_d    = phase_q;

        if (EN) begin
            case (state_q)
                S_ALLRED: begin
                    if (k >= (CNT_W+1)'(ALLRED_T)) begin
                        state_d = S_GREEN;
                        phase_d = pre_act ? pre_ph_w : rr_next;
                    end
                end
                S_GREEN: begin
                    if (pre_act && !pre_hit) begin
                        state_d = S_YELLOW;
                    end else if (!pre_hit && k >= (CNT_W+1)'(GREEN_MIN) && other &&
                                 (!REQ[phase_q] || k >= (CNT_W+1)'(GREEN_MAX))) begin
                        state_d = S_YELLOW;
                    end
                end
                S_YELLOW: begin
                    if (k >= (CNT_W+1)'(YELLOW_T)) begin
                        state_d = S_ALLRED;
                    end
                end
                default: state_d = S_ALLRED;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (EN && cnt_q != CNT_W'(GREEN_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // A request for the phase already holding green is served, so it is not latched.
        green_mask = (state_q == S_GREEN) ? cur_oh : '0;
        pend_d     = pend_q | (REQ & ~green_mask);
        if (state_q != S_GREEN && state_d == S_GREEN) begin
            pend_d[phase_d] = 1'b0;
        end

        nxt_oh = '0;
        nxt_oh[phase_d] = 1'b1;
        grn_d  = (state_d == S_GREEN)  ? nxt_oh : '0;
        yel_d  = (state_d == S_YELLOW) ? nxt_oh : '0;
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q <= S_ALLRED;
            cnt_q   <= '0;
            phase_q <= PW'(NUM_PHASES - 1);
            pend_q  <= '0;
            grn_q   <= '0;
            yel_q   <= '0;
            red_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            grn_q   <= grn_d;
            yel_q   <= yel_d;
            red_q   <= ~(grn_d | yel_d);
        end
    end

    assign GRN       = grn_q;
    assign YEL       = yel_q;
    assign RED       = red_q;
    assign PHASE     = phase_q;
    assign PEND      = pend_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// Directed bench for tlc_multi_phase (default parameters): a vector table for
// gap-out and reset, plus sequences for rest-in-green, max-green, EN strobing and preemption.
module tb_tlc_multi_phase;

    logic       CK;
    logic       RSTN;
    logic       EN;
    logic [2:0] REQ;
    logic [2:0] GRN, YEL, RED, PEND;
    logic [1:0] PHASE;
    logic [1:0] DBG_STATE;
`ifdef TLC_PREEMPT_EN
    logic       PRE_REQ;
    logic [1:0] PRE_PHASE;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic div4   = 1'b0;

    tlc_multi_phase dut (
        .CK       (CK),
        .RSTN     (RSTN),
        .EN       (EN),
        .REQ      (REQ),
        .GRN      (GRN),
        .YEL      (YEL),
        .RED      (RED),
        .PHASE    (PHASE),
        .PEND     (PEND),
`ifdef TLC_PREEMPT_EN
        .PRE_REQ  (PRE_REQ),
        .PRE_PHASE(PRE_PHASE),
`endif
        .DBG_STATE(DBG_STATE)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic step(input logic rstn, input logic [2:0] rq);
        RSTN = rstn;
        REQ  = rq;
        EN   = div4 ? (cyc % 4 == 0) : 1'b1;
        @(posedge CK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        div4 = 1'b0;
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);
        cyc = 0;
    endtask

    // Counts how many cycles the current lamp pattern persists; n0 cycles already seen.
    task automatic measure(input string nm, input logic [2:0] g, input logic [2:0] y,
                           input int n0, input int exp_n, input logic [2:0] rq);
        int n = n0;
        int guard = 0;
        while (GRN == g && YEL == y && guard < 400) begin
            step(1'b1, rq);
            guard++;
            if (GRN == g && YEL == y) n++;
        end
        check(nm, n, exp_n);
    endtask

    typedef struct packed {
        logic       rstn;
        logic [2:0] req;
        logic [2:0] grn;
        logic [2:0] yel;
        logic [2:0] red;
        logic [1:0] ph;
        logic [2:0] pend;
    } vec_t;

    vec_t vt[15];

    initial begin
        RSTN = 1'b0;
        EN   = 1'b1;
        REQ  = 3'b000;
`ifdef TLC_PREEMPT_EN
        PRE_REQ   = 1'b0;
        PRE_PHASE = 2'd0;
`endif

        //          rstn  req     grn     yel     red     ph     pend
        vt[0]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 2'd2, 3'b000};
        vt[1]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 2'd2, 3'b000};
        vt[2]  = '{1'b1, 3'b000, 3'b001, 3'b000, 3'b110, 2'd0, 3'b000};
        vt[3]  = '{1'b1, 3'b100, 3'b001, 3'b000, 3'b110, 2'd0, 3'b100};
        vt[4]  = '{1'b1, 3'b000, 3'b001, 3'b000, 3'b110, 2'd0, 3'b100};
        vt[5]  = '{1'b1, 3'b000, 3'b001, 3'b000, 3'b110, 2'd0, 3'b100};
        vt[6]  = '{1'b1, 3'b000, 3'b000, 3'b001, 3'b110, 2'd0, 3'b100};
        vt[7]  = '{1'b1, 3'b000, 3'b000, 3'b001, 3'b110, 2'd0, 3'b100};
        vt[8]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b111, 2'd0, 3'b100};
        vt[9]  = '{1'b1, 3'b000, 3'b100, 3'b000, 3'b011, 2'd2, 3'b000};
        vt[10] = '{1'b1, 3'b010, 3'b100, 3'b000, 3'b011, 2'd2, 3'b010};
        vt[11] = '{1'b1, 3'b100, 3'b100, 3'b000, 3'b011, 2'd2, 3'b010};
        vt[12] = '{1'b1, 3'b000, 3'b100, 3'b000, 3'b011, 2'd2, 3'b010};
        vt[13] = '{1'b1, 3'b000, 3'b000, 3'b100, 3'b011, 2'd2, 3'b010};
        vt[14] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 2'd2, 3'b000};

        // Reset, gap-out to phase 2 skipping phase 1, own-phase request ignored, reset in yellow
        for (int i = 0; i < 15; i++) begin
            step(vt[i].rstn, vt[i].req);
            check($sformatf("vec%0d_grn", i),   GRN,   vt[i].grn);
            check($sformatf("vec%0d_yel", i),   YEL,   vt[i].yel);
            check($sformatf("vec%0d_red", i),   RED,   vt[i].red);
            check($sformatf("vec%0d_phase", i), PHASE, vt[i].ph);
            check($sformatf("vec%0d_pend", i),  PEND,  vt[i].pend);
        end

        // Rest in green with no competing requests
        do_reset();
        step(1'b1, 3'b000);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 3'b000);
            check($sformatf("rest%0d_lamps", i), {GRN, YEL}, {3'b001, 3'b000});
        end

        // Continuous demand on phase 0 runs out to the maximum green
        do_reset();
        step(1'b1, 3'b000);
        step(1'b1, 3'b011);
        measure("maxgreen_len", 3'b001, 3'b000, 2, 8, 3'b001);
        check("maxgreen_yel", YEL, 3'b001);

        // EN strobing 1-in-4 stretches every interval by four; request with EN=0 is latched
        do_reset();
        div4 = 1'b1;
        step(1'b1, 3'b000);
        step(1'b1, 3'b100);
        check("div4_pend_latched", PEND, 3'b100);
        check("div4_green_hold", GRN, 3'b001);
        measure("div4_green_len", 3'b001, 3'b000, 2, 16, 3'b000);
        measure("div4_yel_len", 3'b000, 3'b001, 1, 8, 3'b000);
        measure("div4_allred_len", 3'b000, 3'b000, 1, 4, 3'b000);
        check("div4_next_green", GRN, 3'b100);
        check("div4_pend_clear", PEND, 3'b000);
        div4 = 1'b0;

`ifdef TLC_PREEMPT_EN
        // Preempt to phase 2 from phase-0 green cycle 1, then hold, then reset during yellow
        do_reset();
        step(1'b1, 3'b000);
        PRE_REQ   = 1'b1;
        PRE_PHASE = 2'd2;
        step(1'b1, 3'b000);
        check("pre_yel_now", YEL, 3'b001);
        measure("pre_yel_len", 3'b000, 3'b001, 1, 2, 3'b000);
        measure("pre_allred_len", 3'b000, 3'b000, 1, 1, 3'b000);
        check("pre_green", GRN, 3'b100);
        check("pre_phase", PHASE, 2'd2);
        begin
            int bad = 0;
            for (int i = 0; i < 25; i++) begin
                step(1'b1, 3'b011);
                if (GRN != 3'b100) bad++;
            end
            check("pre_hold_bad_cycles", bad, 0);
        end
        PRE_REQ = 1'b0;
        step(1'b1, 3'b011);
        check("pre_release_yel", YEL, 3'b100);
        step(1'b0, 3'b000);
        check("pre_rst_red", RED, 3'b111);
        check("pre_rst_lamps", {GRN, YEL}, 6'b000000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
